decode_unit: RTL and testbench

Instruction-decode stage of the single-cycle MIPS datapath. It holds the 32×32-bit general register file and produces the ALU's operand inputs: `read_data_1`, `read_data_2` and the 32-bit extended immediate. It also performs write-back of the ALU result, memory load data or the `jal` link address. It sits directly upstream of the ALU, between instruction fetch/control and the execute stage.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/decode_unit_if.sv | 31 +++
 rtl/decode_unit_reg_file.sv | 35 +++
 rtl/decode_unit.sv | 74 +++++++
 tb/tb_decode_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, special registers and field slices.
// Reused by the decode stage, the main controller and the ALU control.
package mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_JAL  = 6'h03;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    function automatic logic is_logical_imm(input logic [5:0] opc);
        return (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Decode-stage bus: instruction, write-back controls/data and operand outputs.
// master drives the stage inputs; slave is the decode stage itself.
interface decode_unit_if #(
    parameter int DATA_W = 32
);

    logic [31:0]       instruction;
    logic              reg_write;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              jal;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pc_plus_4;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] imm_extended;

    modport master (
        output instruction, reg_write, reg_dst, mem_to_reg, jal,
        output alu_result, mem_data, pc_plus_4,
        input  read_data_1, read_data_2, imm_extended
    );

    modport slave (
        input  instruction, reg_write, reg_dst, mem_to_reg, jal,
        input  alu_result, mem_data, pc_plus_4,
        output read_data_1, read_data_2, imm_extended
    );

endinterface

// File: rtl/decode_unit_reg_file.sv
// General register file: two async read ports, one sync write port,
// async active-low clear, register 0 reads as zero.
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // No write bypass: reads see pre-edge contents.
    assign rdata_1 = (raddr_1 == '0) ? '0 : regs[raddr_1];
    assign rdata_2 = (raddr_2 == '0) ? '0 : regs[raddr_2];

endmodule

// File: rtl/decode_unit.sv
// MIPS instruction-decode stage: register file, immediate extension,
// and write-back destination/data selection.
module decode_unit
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input logic          clk,
    input logic          rst_n,
    decode_unit_if.slave bus
);

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [4:0]        dest;
    logic [DATA_W-1:0] wdata;
    logic              we;

    assign opcode = bus.instruction[OPC_HI:OPC_LO];
    assign rs     = bus.instruction[RS_HI:RS_LO];
    assign rt     = bus.instruction[RT_HI:RT_LO];
    assign rd     = bus.instruction[RD_HI:RD_LO];
    assign imm    = bus.instruction[IMM_HI:IMM_LO];

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        bus.imm_extended = {{(DATA_W-16){imm[15]}}, imm};
        if (is_logical_imm(opcode)) begin
            bus.imm_extended = {{(DATA_W-16){1'b0}}, imm};
        end
    end

    always_comb begin
        dest  = rt;
        wdata = bus.alu_result;
        unique case (1'b1)
            bus.jal: begin
                dest  = REG_RA;
                wdata = bus.pc_plus_4;
            end
            default: begin
                if (bus.reg_dst) begin
                    dest = rd;
                end
                if (bus.mem_to_reg) begin
                    wdata = bus.mem_data;
                end
            end
        endcase
    end

    assign we = (bus.reg_write | bus.jal) && (dest != REG_ZERO);

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .ADDR_W  (5)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_1 (rs),
        .raddr_2 (rt),
        .we      (we),
        .waddr   (dest),
        .wdata   (wdata),
        .rdata_1 (bus.read_data_1),
        .rdata_2 (bus.read_data_2)
    );

endmodule

// File: tb/tb_decode_unit.sv
// Directed self-checking bench for decode_unit.
// Inputs change on the falling edge; outputs are sampled #1 after edges.
module tb_decode_unit;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    decode_unit_if #(.DATA_W(32)) bus ();

    decode_unit #(
        .DATA_W  (32),
        .REG_CNT (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [4:0] rd,
                                       input logic [10:0] low);
        return {op, rs, rt, rd, low};
    endfunction

    task automatic idle_ctrl();
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.jal        = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_imm [5];
        logic [31:0] ins [5];
        rst_n = 1'b0;
        idle_ctrl();
        bus.alu_result = 32'h0;
        bus.mem_data   = 32'h0;
        bus.pc_plus_4  = 32'h0;
        ins[0] = 32'h8C22A011; exp_imm[0] = 32'hFFFFA011;
        ins[1] = 32'h3422A011; exp_imm[1] = 32'h0000A011;
        ins[2] = 32'h3022A011; exp_imm[2] = 32'h0000A011;
        ins[3] = 32'h3822A011; exp_imm[3] = 32'h0000A011;
        ins[4] = 32'h20227FFF; exp_imm[4] = 32'h00007FFF;
        bus.instruction = ins[0];
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0)
            $display("FAIL reset_read rd1=%h rd2=%h required 0/0",
                     bus.read_data_1, bus.read_data_2);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            bus.instruction = ins[i];
            #1;
            total++;
            if (bus.imm_extended !== exp_imm[i])
                $display("FAIL imm_ext[%0d] got=%h required=%h",
                         i, bus.imm_extended, exp_imm[i]);
            else passed++;
        end
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        rst_n = 1'b1;
        idle_ctrl();
        bus.reg_write   = 1'b1;
        bus.instruction = mk(6'h00, 5'd0, 5'd1, 5'd0, 11'd0);
        bus.alu_result  = 32'h0000A011;
        bus.mem_data    = 32'h55555555;
        #1;
        total++;
        if (bus.read_data_2 !== 32'h0)
            $display("FAIL alu_pre_edge got=%h required=0", bus.read_data_2);
        else passed++;
        @(posedge clk);
        #1;
        bus.instruction = mk(6'h00, 5'd1, 5'd0, 5'd0, 11'd0);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0000A011)
            $display("FAIL alu_write got=%h required=0000a011",
                     bus.read_data_1);
        else passed++;
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic test_mem_load();
        @(negedge clk);
        bus.reg_write   = 1'b1;
        bus.reg_dst     = 1'b1;
        bus.mem_to_reg  = 1'b1;
        bus.instruction = mk(6'h00, 5'd0, 5'd6, 5'd5, 11'd0);
        bus.alu_result  = 32'hFFFFFFFF;
        bus.mem_data    = 32'h00004321;
        @(posedge clk);
        #1;
        bus.instruction = mk(6'h00, 5'd5, 5'd6, 5'd0, 11'd0);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h00004321)
            $display("FAIL mem_load got=%h required=00004321",
                     bus.read_data_1);
        else passed++;
        total++;
        if (bus.read_data_2 !== 32'h0)
            $display("FAIL mem_load_rt_untouched got=%h required=0",
                     bus.read_data_2);
        else passed++;
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic test_reg0();
        @(negedge clk);
        bus.reg_write   = 1'b1;
        bus.instruction = mk(6'h00, 5'd0, 5'd0, 5'd0, 11'd0);
        bus.alu_result  = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.reg_dst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0)
            $display("FAIL reg0_protect rd1=%h rd2=%h required 0/0",
                     bus.read_data_1, bus.read_data_2);
        else passed++;
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic test_jal();
        @(negedge clk);
        bus.jal         = 1'b1;
        bus.reg_write   = 1'b0;
        bus.mem_to_reg  = 1'b1;
        bus.instruction = mk(6'h03, 5'd0, 5'd3, 5'd0, 11'd0);
        bus.pc_plus_4   = 32'h00400008;
        bus.alu_result  = 32'h77777777;
        bus.mem_data    = 32'h88888888;
        @(posedge clk);
        #1;
        bus.instruction = mk(6'h00, 5'd31, 5'd3, 5'd0, 11'd0);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h00400008)
            $display("FAIL jal_link got=%h required=00400008",
                     bus.read_data_1);
        else passed++;
        total++;
        if (bus.read_data_2 !== 32'h0)
            $display("FAIL jal_rt_untouched got=%h required=0",
                     bus.read_data_2);
        else passed++;
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.reg_write   = 1'b1;
        bus.instruction = mk(6'h00, 5'd7, 5'd7, 5'd0, 11'd0);
        bus.alu_result  = 32'h00000011;
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0)
            $display("FAIL b2b_no_bypass got=%h required=0",
                     bus.read_data_1);
        else passed++;
        @(negedge clk);
        bus.alu_result = 32'h00000022;
        #1;
        total++;
        if (bus.read_data_1 !== 32'h11 || bus.read_data_2 !== 32'h11)
            $display("FAIL b2b_old_value rd1=%h rd2=%h required 11/11",
                     bus.read_data_1, bus.read_data_2);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h22)
            $display("FAIL b2b_new_value got=%h required=22",
                     bus.read_data_1);
        else passed++;
        @(negedge clk);
        idle_ctrl();
    endtask

    task automatic test_reset_during_write();
        @(negedge clk);
        bus.instruction = mk(6'h00, 5'd1, 5'd1, 5'd0, 11'd0);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0000A011)
            $display("FAIL rst_wr_precond got=%h required=0000a011",
                     bus.read_data_1);
        else passed++;
        bus.reg_write  = 1'b1;
        bus.alu_result = 32'h00001234;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0)
            $display("FAIL rst_async got=%h required=0", bus.read_data_1);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0)
            $display("FAIL rst_blocks_write rd1=%h rd2=%h required 0/0",
                     bus.read_data_1, bus.read_data_2);
        else passed++;
        @(negedge clk);
        idle_ctrl();
        rst_n = 1'b1;
        bus.instruction = mk(6'h00, 5'd31, 5'd5, 5'd0, 11'd0);
        #1;
        total++;
        if (bus.read_data_1 !== 32'h0 || bus.read_data_2 !== 32'h0)
            $display("FAIL rst_clears_all rd1=%h rd2=%h required 0/0",
                     bus.read_data_1, bus.read_data_2);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_alu_write();
        test_mem_load();
        test_reg0();
        test_jal();
        test_back_to_back();
        test_reset_during_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
